// File: rtl/axis_result_packer_if.sv
// axis_result_packer_if: AXI-Stream bundle used on both sides of the packer
interface axis_result_packer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] TDATA;
  logic [KEEP_WIDTH-1:0] TKEEP;
  logic                  TLAST;
  logic                  TVALID;
  logic                  TREADY;
  modport master (output TDATA, TKEEP, TLAST, TVALID, input TREADY);
  modport slave  (input TDATA, TKEEP, TLAST, TVALID, output TREADY);
endinterface

// File: rtl/axis_result_packer.sv
// axis_result_packer: packs byte-per-beat results into 32-bit words behind a small FIFO
module axis_result_packer #(
  parameter int DATA_WIDTH     = 32,
  parameter int PAYLOAD_WIDTH  = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  axis_result_packer_if.slave  S_AXIS,
  axis_result_packer_if.master M_AXIS,
  output logic [CNT_WIDTH-1:0] pkt_count
);
  localparam int LW = $clog2(BYTES_PER_WORD);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_WIDTH + BYTES_PER_WORD + 1;
  logic                      ready_q;
  logic [LW-1:0]             lane;
  logic [DATA_WIDTH-1:0]     acc, acc_nxt;
  logic [BYTES_PER_WORD-1:0] keep, keep_nxt;
  logic [EW-1:0]             mem [FIFO_DEPTH];
  logic [EW-1:0]             head;
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [AW:0]               fifo_count;
  logic                      s_fire, m_fire, done;
  logic                      unused;
  // Handshakes come from registers only; outputs are forced to 0 whenever the FIFO is empty
  always_comb begin
    S_AXIS.TREADY = ready_q & (fifo_count < (AW+1)'(FIFO_DEPTH));
    M_AXIS.TVALID = fifo_count != '0;
    s_fire = S_AXIS.TVALID & S_AXIS.TREADY;
    m_fire = M_AXIS.TVALID & M_AXIS.TREADY;
    done = s_fire & ((lane == LW'(BYTES_PER_WORD - 1)) | S_AXIS.TLAST);
    acc_nxt = acc | (DATA_WIDTH'(S_AXIS.TDATA[PAYLOAD_WIDTH-1:0]) << (lane * PAYLOAD_WIDTH));
    keep_nxt = keep | (BYTES_PER_WORD'(1) << lane);
    head = M_AXIS.TVALID ? mem[rd_ptr] : '0;
    {M_AXIS.TDATA, M_AXIS.TKEEP, M_AXIS.TLAST} = head;
    unused = ^{S_AXIS.TDATA[DATA_WIDTH-1:PAYLOAD_WIDTH], S_AXIS.TKEEP};
  end
  // Accumulate payloads into lanes; a completed word restarts at lane 0 with empty lanes
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ready_q <= 1'b0;
      lane    <= '0;
      acc     <= '0;
      keep    <= '0;
    end else begin
      ready_q <= 1'b1;
      if (s_fire) begin
        lane <= done ? '0 : lane + 1'b1;
        acc  <= done ? '0 : acc_nxt;
        keep <= done ? '0 : keep_nxt;
      end
    end
  end
  // FIFO pointers wrap naturally since the depth is a power of two
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      pkt_count  <= '0;
    end else begin
      if (done) wr_ptr <= wr_ptr + 1'b1;
      if (m_fire) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + (AW+1)'(done) - (AW+1)'(m_fire);
      if (m_fire & M_AXIS.TLAST) pkt_count <= pkt_count + 1'b1;
    end
  end
  // Packed word storage; contents past the pointers are don't-care so no reset is needed
  always_ff @(posedge ACLK) begin
    if (done) mem[wr_ptr] <= {acc_nxt, keep_nxt, S_AXIS.TLAST};
  end
endmodule
